// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: queues nonzero operand pairs and sequences them into a GCD controller
// via proceed/done, with a per-job watchdog that forces the head out after TIMEOUT WAIT cycles.
module gcd_operand_feeder #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     in_ready,
    output logic                     proceed,
    output logic [WIDTH-1:0]         xin,
    output logic [WIDTH-1:0]         yin,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_zero,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail, head_n;
    logic [AW:0] count_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic hs, push, pop, expire;
    assign in_ready = count < (AW+1)'(DEPTH) && !rst;
    assign hs       = in_valid && in_ready;
    assign push     = hs && in_a != '0 && in_b != '0;
    assign expire   = state == WAIT && tcnt == TW'(TIMEOUT - 1);
    assign pop      = state == WAIT && (done || expire);
    assign head_n   = head + AW'(pop);
    assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);
    always_comb begin
        state_n = state == IDLE  ? (count != '0 ? ISSUE : IDLE) :
                  state == ISSUE ? WAIT : (pop && count_n == '0 ? IDLE : WAIT);
        tcnt_n  = state == WAIT && !pop ? tcnt + TW'(1) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            tcnt     <= '0;
            proceed  <= 1'b0;
            xin      <= '0;
            yin      <= '0;
            err_zero <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            head     <= head_n;
            tail     <= tail + AW'(push);
            count    <= count_n;
            tcnt     <= tcnt_n;
            proceed  <= state_n != IDLE;
            err_zero <= hs && !push;
            timeout  <= timeout || expire;
            // the new head may be the pair being written this very cycle
            if (count_n != '0) {xin, yin} <= push && head_n == tail ? {in_a, in_b} : mem[head_n];
        end
    end
    always_ff @(posedge clk)
        if (push) mem[tail] <= {in_a, in_b};
endmodule

// File: tb/tb_gcd_operand_feeder.sv
// tb_gcd_operand_feeder: random traffic with an ordered-pair scoreboard; a monitor checks
// occupancy, handshake, proceed sequencing, head operands, zero drops and the watchdog.
module tb_gcd_operand_feeder;
    localparam int WIDTH = 8, DEPTH = 4, TIMEOUT = 8;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, done = 1'b0;
    logic [WIDTH-1:0] in_a = '0, in_b = '0;
    logic in_ready, proceed, err_zero, timeout;
    logic [WIDTH-1:0] xin, yin;
    logic [$clog2(DEPTH):0] count;
    int compared = 0, mismatched = 0;
    logic [2*WIDTH-1:0] sb [$];
    logic [2*WIDTH-1:0] exp_xy = '0, last_xy = '0;
    logic exp_p = 1'b0, exp_pp = 1'b0, exp_err = 1'b0, exp_to = 1'b0;
    bit in_wait, popped;
    int wc = 0, sz0;

    always #5 clk = ~clk;

    gcd_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .proceed(proceed), .xin(xin), .yin(yin), .done(done),
        .count(count), .err_zero(err_zero), .timeout(timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: models each clock edge from the spec's rules, then compares what the DUT shows
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_p = 0; exp_pp = 0; exp_err = 0; exp_to = 0; exp_xy = '0; wc = 0;
        end else begin
            sz0 = sb.size();
            in_wait = exp_p && exp_pp;
            popped = 0;
            wc = in_wait ? wc + 1 : 0;
            if (in_wait && (done || wc == TIMEOUT)) begin
                popped = 1;
                if (wc == TIMEOUT) exp_to = 1;
                if (sz0 == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL pop_head: job completed with no queued pair at %0t", $time);
                end else begin
                    check("pop_head", int'(last_xy), int'(sb[0]));
                    void'(sb.pop_front());
                end
                wc = 0;
            end
            exp_err = in_valid && sz0 < DEPTH && (in_a == '0 || in_b == '0);
            if (in_valid && sz0 < DEPTH && in_a != '0 && in_b != '0) sb.push_back({in_a, in_b});
            exp_pp = exp_p;
            exp_p = exp_p ? !(popped && sb.size() == 0) : sz0 > 0;
            if (sb.size() > 0) exp_xy = sb[0];
        end
        check("count", int'(count), sb.size());
        check("in_ready", int'(in_ready), int'(sb.size() < DEPTH && !rst));
        check("proceed", int'(proceed), int'(exp_p));
        check("err_zero", int'(err_zero), int'(exp_err));
        check("timeout", int'(timeout), int'(exp_to));
        check("head_xy", int'({xin, yin}), int'(exp_xy));
        last_xy = {xin, yin};
    end

    // stimulus: random pairs (some with zero operands), random done pulses, rare resets
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst      = $urandom_range(0, 299) == 0;
            in_valid = $urandom_range(0, 2) != 0;
            in_a     = $urandom_range(0, 7) == 0 ? '0 : WIDTH'($urandom);
            in_b     = $urandom_range(0, 7) == 0 ? '0 : WIDTH'($urandom);
            done     = $urandom_range(0, 5) == 0;
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gcd_operand_feeder.md
GCD_OPERAND_FEEDER -- requirements
Module: gcd_operand_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the operand queue depth in pairs; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum number of cycles a job may spend in WAIT.
REQ-004 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port in_valid: input, 1 bit, upstream offers an operand pair.
REQ-008 Port in_a: input, WIDTH bits, first operand.
REQ-009 Port in_b: input, WIDTH bits, second operand.
REQ-010 Port in_ready: output, 1 bit, block accepts a pair this cycle.
REQ-011 Port proceed: output, 1 bit, start/continue request to the GCD controller.
REQ-012 Port xin: output, WIDTH bits, operand for the X register load path.
REQ-013 Port yin: output, WIDTH bits, operand for the Y register load path.
REQ-014 Port done: input, 1 bit, controller result-enable pulse marking job completion.
REQ-015 Port count: output, clog2(DEPTH)+1 bits, number of queued pairs.
REQ-016 Port err_zero: output, 1 bit, one-cycle pulse when a pair with a zero operand is dropped.
REQ-017 Port timeout: output, 1 bit, sticky flag set when a job exceeds TIMEOUT cycles.

Function
REQ-018 The queue SHALL be a circular FIFO of DEPTH entries with wrapping head and tail pointers; count SHALL track occupancy 0..DEPTH.
REQ-019 in_ready SHALL equal (count < DEPTH) && !rst; there SHALL be no bypass, so a full queue refuses a push even in a pop cycle.
REQ-020 A push SHALL occur when in_valid && in_ready && in_a != 0 && in_b != 0, storing {in_a, in_b} at tail.
REQ-021 A handshake with in_a == 0 or in_b == 0 SHALL complete (pair consumed) without a write, and err_zero SHALL be high in the following cycle only.
REQ-022 When a push and a pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 xin/yin SHALL be registered and SHALL always show the head entry; they SHALL hold their last value while the queue is empty.
REQ-024 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-025 IDLE: proceed=0; when count>0, the FSM SHALL go to ISSUE next cycle.
REQ-026 ISSUE: proceed=1 and the timeout counter is cleared; the FSM SHALL go to WAIT next cycle.
REQ-027 WAIT: proceed=1; the timeout counter SHALL increment each cycle.
REQ-028 WAIT, on done=1: pop the head; if count after the pop is greater than 0, stay in WAIT with the counter cleared and the next head on xin/yin in the following cycle; otherwise go to IDLE with proceed=0 in the following cycle.
REQ-029 The timing in REQ-028 SHALL guarantee that new operands are stable at least one cycle before the controller's next load cycle (done -> reset state -> load).
REQ-030 done SHALL be ignored in IDLE and ISSUE.
REQ-031 In WAIT, when the counter reaches TIMEOUT, timeout SHALL set, the head SHALL be popped as if done, and the FSM SHALL follow the REQ-028 rules.
REQ-032 timeout SHALL clear only on rst.
REQ-033 proceed SHALL be a registered, state-decoded output with no glitches.

Reset
REQ-034 On rst=1 at a clk edge: state=IDLE, head=tail=0, count=0, proceed=0, xin=yin=0, err_zero=0, timeout=0, and the timeout counter=0.
REQ-035 rst asserted mid-job SHALL discard all queued pairs and the in-flight job; the first cycle after reset SHALL show in_ready=1.

Verification
REQ-036 Scenario: push (36,24) from IDLE -> count=1, ISSUE one cycle later, then WAIT with xin=36, yin=24, proceed=1; done pulse -> proceed=0 next cycle, count=0.
REQ-037 Scenario: push (12,18), (7,7), (9,6) back-to-back; first done -> next cycle xin=7, yin=7, proceed stays 1, count=2.
REQ-038 Scenario: push 4 pairs with DEPTH=4 and no done -> in_ready=0; in_valid held with a done pulse -> no push in the pop cycle, push accepted next cycle.
REQ-039 Scenario: push (0,15) -> handshake completes, count unchanged, err_zero=1 for exactly one cycle.
REQ-040 Scenario: TIMEOUT=8, one pair pushed, done withheld -> timeout=1 and head popped 8 cycles after entering WAIT, FSM in IDLE.
REQ-041 Scenario: rst during WAIT with count=3 -> next cycle count=0, proceed=0, xin=yin=0, in_ready=1.
